// File: rtl/amba_axi_pkg.sv
// Shared AXI4 types for the interconnect: burst/size/response encodings and
// the manager-to-subordinate (mosi) / subordinate-to-manager (miso) bundles.
package amba_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_USER_W = 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef logic [2:0] axi_size_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_error_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    axi_size_t               awsize;
    axi_burst_t              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    axi_size_t               arsize;
    axi_burst_t              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    axi_error_t              bresp;
    logic [AXI_USER_W-1:0]   buser;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    axi_error_t              rresp;
    logic                    rlast;
    logic [AXI_USER_W-1:0]   ruser;
    logic                    rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// WRAP with a non-power-of-two beat count degrades to INCR.
module axi_beat_addr_gen
  import amba_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  axi_size_t         size,
  input  logic [7:0]        len,
  input  axi_burst_t        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  always_comb begin
    step      = ADDR_W'(1) << size;
    incr_addr = addr + step;
    // window = (len+1) beats of 2^size bytes, aligned to its own size
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    wrap_ok   = len inside {8'd1, 8'd3, 8'd7, 8'd15};
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_rom_burst_adapter.sv
// Splits upstream AXI read bursts into single-beat reads for a boot ROM and
// answers any upstream write with SLVERR after draining its data.
module axi_rom_burst_adapter
  import amba_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t s_mosi,
  output s_axi_miso_t s_miso,
  output s_axi_mosi_t m_mosi,
  input  s_axi_miso_t m_miso
);

  typedef enum logic [2:0] {IDLE, AR_ISSUE, R_WAIT, W_DRAIN, B_RESP} state_t;

  state_t                 state, state_n;
  logic [7:0]             cnt;
  logic [AXI_ID_W-1:0]    rd_id;
  logic [AXI_ID_W-1:0]    wr_id;
  logic [AXI_ADDR_W-1:0]  addr;
  logic [AXI_ADDR_W-1:0]  addr_nxt;
  logic [ADDR_W-1:0]      beat_next;
  logic [7:0]             len;
  axi_size_t              size;
  axi_burst_t             burst;
  logic                   last_beat;
  logic                   r_hs;

  axi_beat_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr[ADDR_W-1:0]),
    .size      (size),
    .len       (len),
    .burst     (burst),
    .next_addr (beat_next)
  );

  // Bits above the arithmetic width ride along unchanged.
  generate
    if (ADDR_W >= AXI_ADDR_W) begin : g_full
      assign addr_nxt = beat_next[AXI_ADDR_W-1:0];
    end else begin : g_part
      assign addr_nxt = {addr[AXI_ADDR_W-1:ADDR_W], beat_next};
    end
  endgenerate

  assign last_beat = (cnt == len);
  assign r_hs      = m_miso.rvalid && s_mosi.rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rd_id <= '0;
      wr_id <= '0;
      addr  <= '0;
      len   <= '0;
      size  <= '0;
      burst <= BURST_FIXED;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (s_mosi.arvalid) begin
            rd_id <= s_mosi.arid;
            addr  <= s_mosi.araddr;
            len   <= s_mosi.arlen;
            size  <= s_mosi.arsize;
            burst <= s_mosi.arburst;
            cnt   <= '0;
          end else if (s_mosi.awvalid) begin
            wr_id <= s_mosi.awid;
          end
        end
        R_WAIT: begin
          if (r_hs && !last_beat) begin
            addr <= addr_nxt;
            cnt  <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while rst is held so a mid-burst reset never
  // leaks a stale beat upstream.
  always_comb begin
    state_n       = state;
    s_miso        = '0;
    m_mosi        = '0;
    m_mosi.bready = 1'b1;
    if (!rst) begin
      case (state)
        IDLE: begin
          s_miso.arready = 1'b1;
          if (s_mosi.arvalid) begin
            state_n = AR_ISSUE;
          end else if (s_mosi.awvalid) begin
            s_miso.awready = 1'b1;
            state_n        = W_DRAIN;
          end
        end
        AR_ISSUE: begin
          m_mosi.arvalid = 1'b1;
          m_mosi.araddr  = addr;
          m_mosi.arlen   = 8'd0;
          m_mosi.arsize  = size;
          m_mosi.arburst = BURST_INCR;
          m_mosi.arid    = rd_id;
          if (m_miso.arready) state_n = R_WAIT;
        end
        R_WAIT: begin
          m_mosi.rready = s_mosi.rready;
          s_miso.rvalid = m_miso.rvalid;
          s_miso.rdata  = m_miso.rdata;
          s_miso.rresp  = m_miso.rresp;
          s_miso.rid    = rd_id;
          s_miso.rlast  = last_beat;
          if (r_hs) state_n = last_beat ? IDLE : AR_ISSUE;
        end
        W_DRAIN: begin
          s_miso.wready = 1'b1;
          if (s_mosi.wvalid && s_mosi.wlast) state_n = B_RESP;
        end
        B_RESP: begin
          s_miso.bvalid = 1'b1;
          s_miso.bresp  = RESP_SLVERR;
          s_miso.bid    = wr_id;
          if (s_mosi.bready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{m_miso.awready, m_miso.wready, m_miso.bid, m_miso.bresp, m_miso.buser,
                       m_miso.bvalid, m_miso.rid, m_miso.rlast, m_miso.ruser,
                       s_mosi.awaddr, s_mosi.awlen, s_mosi.awsize, s_mosi.awburst,
                       s_mosi.wdata, s_mosi.wstrb};

endmodule

// File: tb/tb_axi_rom_burst_adapter.sv
// Bench for axi_rom_burst_adapter: ROM model downstream, scoreboard queues for
// downstream addresses and upstream beats, table of read bursts plus corner sequences.
module tb_axi_rom_burst_adapter;
  import amba_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t s_mosi;
  s_axi_miso_t s_miso;
  s_axi_mosi_t m_mosi;
  s_axi_miso_t m_miso;

  always #5 clk = ~clk;

  axi_rom_burst_adapter #(.ADDR_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_mosi (s_mosi),
    .s_miso (s_miso),
    .m_mosi (m_mosi),
    .m_miso (m_miso)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // single-beat ROM: accepts when idle, returns data the next cycle
  logic        rom_rvalid;
  logic [31:0] rom_rdata;
  always @(posedge clk) begin
    if (rst) begin
      rom_rvalid <= 1'b0;
      rom_rdata  <= '0;
    end else if (m_mosi.arvalid && !rom_rvalid) begin
      rom_rvalid <= 1'b1;
      rom_rdata  <= rom_f(m_mosi.araddr);
    end else if (rom_rvalid && m_mosi.rready) begin
      rom_rvalid <= 1'b0;
    end
  end

  always_comb begin
    m_miso         = '0;
    m_miso.arready = !rom_rvalid;
    m_miso.rvalid  = rom_rvalid;
    m_miso.rdata   = rom_rdata;
    m_miso.rresp   = RESP_OKAY;
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] addr_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          dn_wr_viol = 0;
  int          beats_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [31:0] mon_a;
  beat_t       mon_b;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_mosi.awvalid || m_mosi.wvalid || !m_mosi.bready || s_miso.ruser != 0 || s_miso.buser != 0)
        dn_wr_viol++;
      if (m_mosi.arvalid && m_miso.arready) begin
        if (addr_q.size() == 0) chk("dn_ar_unexpected", 1, 0);
        else begin
          mon_a = addr_q.pop_front();
          chk("dn_araddr", m_mosi.araddr, mon_a);
          chk("dn_arlen", m_mosi.arlen, 0);
        end
      end
      if (s_miso.rvalid && s_mosi.rready) begin
        beats_seen++;
        if (beat_q.size() == 0) chk("up_beat_unexpected", 1, 0);
        else begin
          mon_b = beat_q.pop_front();
          chk("rdata", s_miso.rdata, mon_b.data);
          chk("rlast", s_miso.rlast, mon_b.last);
          chk("rid", s_miso.rid, mon_b.id);
          chk("rresp", s_miso.rresp, RESP_OKAY);
        end
      end
    end
  end

  task automatic push_beat(input logic [3:0] id, input logic [31:0] a, input logic last);
    beat_t b;
    b.data = rom_f(a);
    b.last = last;
    b.id   = id;
    addr_q.push_back(a);
    beat_q.push_back(b);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input axi_burst_t burst);
    bit ok = 0;
    @(posedge clk); #1;
    s_mosi.arid    = id;
    s_mosi.araddr  = a;
    s_mosi.arlen   = len;
    s_mosi.arsize  = size;
    s_mosi.arburst = burst;
    s_mosi.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_miso.arready) begin ok = 1; break; end
    end
    if (!ok) chk("ar_accept_timeout", 0, 1);
    @(posedge clk); #1;
    s_mosi.arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (beat_q.size() == 0 && addr_q.size() == 0) break;
    end
    chk(name, beat_q.size() + addr_q.size(), 0);
  endtask

  task automatic write_data_resp(input logic [3:0] id);
    bit ok;
    for (int b = 0; b < 4; b++) begin
      s_mosi.wvalid = 1'b1;
      s_mosi.wlast  = (b == 3);
      s_mosi.wdata  = $urandom;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_miso.wready) begin ok = 1; break; end
      end
      if (!ok) chk("wready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    s_mosi.wvalid = 1'b0;
    s_mosi.wlast  = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_miso.bvalid) begin ok = 1; break; end
    end
    chk("bvalid_seen", ok, 1);
    chk("bresp", s_miso.bresp, RESP_SLVERR);
    chk("bid", s_miso.bid, id);
    @(negedge clk);
    chk("bvalid_drop", s_miso.bvalid, 0);
  endtask

  typedef struct packed {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    axi_burst_t       burst;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int k, input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] size, input axi_burst_t burst,
                         input logic [31:0] e0, e1, e2, e3);
    vecs[k].id     = id;
    vecs[k].addr   = a;
    vecs[k].len    = len;
    vecs[k].size   = size;
    vecs[k].burst  = burst;
    vecs[k].exp[0] = e0;
    vecs[k].exp[1] = e1;
    vecs[k].exp[2] = e2;
    vecs[k].exp[3] = e3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    set_vec(0, 4'h1, 32'h100, 8'd3, 3'd2, BURST_INCR,  32'h100, 32'h104, 32'h108, 32'h10C);
    set_vec(1, 4'h2, 32'h108, 8'd3, 3'd2, BURST_WRAP,  32'h108, 32'h10C, 32'h100, 32'h104);
    set_vec(2, 4'h3, 32'h020, 8'd2, 3'd2, BURST_FIXED, 32'h020, 32'h020, 32'h020, 32'h0);
    set_vec(3, 4'h4, 32'h108, 8'd2, 3'd2, BURST_WRAP,  32'h108, 32'h10C, 32'h110, 32'h0);
    set_vec(4, 4'h5, 32'h007, 8'd0, 3'd0, BURST_INCR,  32'h007, 32'h0,   32'h0,   32'h0);
    set_vec(5, 4'h6, 32'h038, 8'd1, 3'd3, BURST_WRAP,  32'h038, 32'h030, 32'h0,   32'h0);

    rst           = 1'b1;
    s_mosi        = '0;
    s_mosi.rready = 1'b1;
    s_mosi.bready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", s_miso.arready, 0);
    chk("rst_quiet", {s_miso.rvalid, s_miso.bvalid, s_miso.awready, s_miso.wready, m_mosi.arvalid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", s_miso.arready, 1);

    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b <= int'(vecs[k].len); b++)
        push_beat(vecs[k].id, vecs[k].exp[b], b == int'(vecs[k].len));
      send_ar(vecs[k].id, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst);
      wait_drain($sformatf("vec%0d_drain", k));
    end

    // upstream stall on beat 0
    s_mosi.rready = 1'b0;
    push_beat(4'h7, 32'h40, 1'b0);
    push_beat(4'h7, 32'h44, 1'b1);
    send_ar(4'h7, 32'h40, 8'd1, 3'd2, BURST_INCR);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_miso.rvalid) begin ok = 1; break; end
    end
    chk("stall_rvalid_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", s_miso.rvalid, 1);
      chk("stall_rdata", s_miso.rdata, rom_f(32'h40));
    end
    @(posedge clk); #1;
    s_mosi.rready = 1'b1;
    wait_drain("stall_drain");

    // plain write: drained and refused
    @(posedge clk); #1;
    s_mosi.awid    = 4'd5;
    s_mosi.awvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_miso.awready) begin ok = 1; break; end
    end
    chk("aw_accept", ok, 1);
    @(posedge clk); #1;
    s_mosi.awvalid = 1'b0;
    write_data_resp(4'd5);

    // simultaneous AR and AW: read wins
    @(posedge clk); #1;
    push_beat(4'h2, 32'h80, 1'b0);
    push_beat(4'h2, 32'h84, 1'b1);
    s_mosi.arid    = 4'h2;
    s_mosi.araddr  = 32'h80;
    s_mosi.arlen   = 8'd1;
    s_mosi.arsize  = 3'd2;
    s_mosi.arburst = BURST_INCR;
    s_mosi.arvalid = 1'b1;
    s_mosi.awid    = 4'd9;
    s_mosi.awvalid = 1'b1;
    @(negedge clk);
    chk("prio_arready", s_miso.arready, 1);
    chk("prio_awready", s_miso.awready, 0);
    @(posedge clk); #1;
    s_mosi.arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_miso.awready) begin ok = 1; break; end
    end
    chk("prio_aw_later", ok, 1);
    chk("prio_read_first", beat_q.size() + addr_q.size(), 0);
    @(posedge clk); #1;
    s_mosi.awvalid = 1'b0;
    write_data_resp(4'd9);

    // reset during beat 2 of an 8-beat burst
    for (int b = 0; b < 8; b++) push_beat(4'hA, 32'h200 + 32'(4 * b), b == 7);
    beats_seen = 0;
    send_ar(4'hA, 32'h200, 8'd7, 3'd2, BURST_INCR);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beats_seen >= 2) begin ok = 1; break; end
    end
    chk("rst_burst_progress", ok, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    beat_q.delete();
    addr_q.delete();
    @(negedge clk);
    chk("midrst_rvalid", s_miso.rvalid, 0);
    chk("midrst_arready", s_miso.arready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_arready", s_miso.arready, 1);
    chk("after_rst_rvalid", s_miso.rvalid, 0);
    push_beat(4'hB, 32'h1F0, 1'b1);
    send_ar(4'hB, 32'h1F0, 8'd0, 3'd2, BURST_INCR);
    wait_drain("after_rst_drain");

    chk("no_dn_write", dn_wr_viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_rom_burst_adapter.md
AXI_ROM_BURST_ADAPTER -- requirements
Module: axi_rom_burst_adapter

Interface
REQ-001 Parameter ADDR_W, default 32, meaning: significant address bits used for beat-address arithmetic.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_mosi  input  s_axi_mosi_t  upstream AXI manager request (interconnect side).
REQ-005 s_miso  output  s_axi_miso_t  upstream response.
REQ-006 m_mosi  output  s_axi_mosi_t  downstream request to single-beat read-only slave (boot ROM wrapper).
REQ-007 m_miso  input  s_axi_miso_t  downstream response; only arready, rvalid, rdata, rresp used.

Function
REQ-008 The block SHALL split each upstream AR burst into arlen+1 single-beat downstream reads and return the beats upstream in order, with rlast=1 only on the final beat.
REQ-009 The FSM SHALL have states IDLE, AR_ISSUE, R_WAIT, W_DRAIN, B_RESP.
REQ-010 IDLE: s_miso.arready=1; on arvalid, latch arid, araddr, arlen, arsize, arburst and set beat counter=0 -> AR_ISSUE; arvalid takes priority over a simultaneous awvalid.
REQ-011 IDLE with awvalid and no arvalid: s_miso.awready=1; latch awid -> W_DRAIN.
REQ-012 AR_ISSUE: m_mosi.arvalid=1, araddr=current beat address, arlen=0, arsize=latched, arburst=INCR, arid=latched; on m_miso.arready -> R_WAIT.
REQ-013 R_WAIT: m_mosi.rready=s_mosi.rready; s_miso.rvalid=m_miso.rvalid; rdata and rresp pass through; rid=latched id; on rvalid&&rready: final beat -> IDLE, else advance address, counter+1 -> AR_ISSUE.
REQ-014 Beat address SHALL advance: FIXED unchanged; INCR +2^arsize; WRAP +2^arsize wrapping within a (arlen+1)*2^arsize aligned window.
REQ-015 Upstream WRAP with arlen not in {1,3,7,15} SHALL be handled as INCR.
REQ-016 Upstream stall (rready=0) SHALL hold the downstream beat pending; no beat is dropped or duplicated.
REQ-017 W_DRAIN: s_miso.wready=1; discard data; on wvalid&&wlast -> B_RESP.
REQ-018 B_RESP: s_miso.bvalid=1, bresp=SLVERR, bid=latched awid; on bready -> IDLE.
REQ-019 Downstream write channels (awvalid, wvalid) SHALL be held 0; m_mosi.bready=1.
REQ-020 Unused response fields (ruser, buser) SHALL be 0.
REQ-021 Minimum latency per beat: AR issue cycle + downstream latency (ROM: 1 cycle) → 2 cycles/beat with zero stall.

Reset
REQ-022 On rst: state=IDLE, counter=0, latched fields=0; s_miso.rvalid=0, bvalid=0, awready=0, wready=0, arready=0 during reset; m_mosi.arvalid=0.
REQ-023 Reset mid-burst SHALL abandon the burst; first cycle after reset deasserted has arready=1 and no stale rvalid.

Structure
REQ-024 axi_burst_t, axi_size_t, axi_error_t and the mosi/miso structs SHALL come from amba_axi_pkg; the FSM state enum SHALL be local.
REQ-025 Next-address computation SHALL live in sub-module axi_beat_addr_gen (combinational: addr, size, len, burst -> next addr).

Verification
REQ-026 INCR arlen=3 arsize=2 araddr=0x100 -> downstream addrs 0x100,0x104,0x108,0x10C; 4 beats upstream, rlast only on 4th, rid=arid.
REQ-027 WRAP arlen=3 arsize=2 araddr=0x108 -> addrs 0x108,0x10C,0x100,0x104.
REQ-028 FIXED arlen=2 araddr=0x20 -> three reads at 0x20, identical data, rlast on 3rd.
REQ-029 INCR arlen=1 with s_mosi.rready=0 for 5 cycles on beat 0 -> rvalid held, rdata stable, exactly 2 beats delivered.
REQ-030 AW id=5 + 4 W beats (wlast on 4th) -> bvalid with bresp=SLVERR, bid=5, no downstream write activity; simultaneous arvalid+awvalid in IDLE -> read served first.
REQ-031 rst asserted during beat 2 of arlen=7 burst -> rvalid=0 next cycle, IDLE with arready=1 after release, subsequent arlen=0 read correct.
